// File: rtl/times3_pkg.sv
// Shared definitions for the bit-serial 3N (AN-code, A=3) encoder.
//   W_DEF    : default operand width
//   state_t  : controller states, 2-bit encoded
//   LAST_IDX : index of the last result bit for the default width
//   last_idx : the same quantity for any width
package times3_pkg;

  localparam int W_DEF    = 64;
  localparam int LAST_IDX = W_DEF + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int last_idx(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/serial_add_cell.sv
// Combinational 3-input bit adder used by the serial 3N encoder.
// It adds the current operand bit, the previous operand bit (x<<1 term)
// and the running carry.
//   b     : current operand bit (x term)
//   prev  : previous operand bit (2x term)
//   carry : carry from the previous step
//   sum   : result bit for this step
//   cout  : carry into the next step
module serial_add_cell (
  input  logic b,
  input  logic prev,
  input  logic carry,
  output logic sum,
  output logic cout
);

  // Largest sum is 3, so two bits always suffice.
  assign {cout, sum} = {1'b0, b} + {1'b0, prev} + {1'b0, carry};

endmodule

// File: rtl/serial_times3_encoder.sv
// Bit-serial 3N encoder: y = 3*x = x + (x<<1), produced LSB-first, one bit
// per clock.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   x     : W-bit operand, sampled on the load edge only
//   e     : level enable; rising starts a run, low returns to idle
//   y     : W+2-bit result, built bit by bit, final while f=1
//   f     : result valid
//   i     : index of the bit being produced (0..W+1), W+2 when done
//   busy  : high while the result is being produced
module serial_times3_encoder
  import times3_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int IW = $clog2(W + 3)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  x,
  input  logic          e,
  output logic [W+1:0]  y,
  output logic          f,
  output logic [IW-1:0] i,
  output logic          busy
);

  localparam logic [IW-1:0] LAST_I = IW'(last_idx(W));
  localparam logic [IW-1:0] DONE_I = IW'(W + 2);

  state_t       state;
  logic [W-1:0] sh;
  logic         prev;
  logic         carry;
  logic         sum;
  logic         cout;

  serial_add_cell u_add (
    .b     (sh[0]),
    .prev  (prev),
    .carry (carry),
    .sum   (sum),
    .cout  (cout)
  );

  // NOTE: every register here uses non-blocking assignment so that all
  // updates within one edge see the pre-edge values (prev <= sh[0] must use
  // the bit that sum was just built from).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sh    <= '0;
      prev  <= 1'b0;
      carry <= 1'b0;
      y     <= '0;
      f     <= 1'b0;
      i     <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (e) begin
            sh    <= x;
            prev  <= 1'b0;
            carry <= 1'b0;
            y     <= '0;
            i     <= '0;
            busy  <= 1'b1;
            f     <= 1'b0;
            state <= RUN;
          end
        end

        RUN: begin
          if (!e) begin
            // Abort: the partial result is discarded.
            y     <= '0;
            f     <= 1'b0;
            i     <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            // y was cleared on load, so OR-ing in the new bit places it.
            y     <= y | ((W + 2)'(sum) << i);
            carry <= cout;
            prev  <= sh[0];
            // Zero fill lets the last two steps flush prev and carry.
            sh    <= sh >> 1;
            if (i == LAST_I) begin
              f     <= 1'b1;
              busy  <= 1'b0;
              i     <= DONE_I;
              state <= DONE;
            end else begin
              i <= i + 1'b1;
            end
          end
        end

        DONE: begin
          // Hold until e drops; no restart while e stays high.
          if (!e) begin
            f     <= 1'b0;
            i     <= '0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_times3_encoder.sv
// Directed self-checking bench for serial_times3_encoder (W=64).
module tb_serial_times3_encoder;

  logic        clk;
  logic        rst_n;
  logic [63:0] x;
  logic        e;
  logic [65:0] y;
  logic        f;
  logic [6:0]  i;
  logic        busy;

  int errors;
  int checks;

  serial_times3_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (x),
    .e     (e),
    .y     (y),
    .f     (f),
    .i     (i),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs must equal the idle pattern with the given retained y.
  task automatic expect_idle(input string name, input logic [65:0] yexp);
    checks++;
    if (y !== yexp || f !== 1'b0 || i !== 7'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: y=%0h f=%0b i=%0d busy=%0b, expected y=%0h f=0 i=0 busy=0",
               name, y, f, i, busy, yexp);
    end
  endtask

  // Load xv, then scramble x and wait for f; leaves e high in DONE.
  task automatic run_op(input logic [63:0] xv, input logic [65:0] yexp, input string name);
    int lat;
    x = xv;
    e = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || f !== 1'b0 || i !== 7'd0 || y !== 66'd0) begin
      errors++;
      $display("FAIL %s_load: busy=%0b f=%0b i=%0d y=%0h, expected busy=1 f=0 i=0 y=0",
               name, busy, f, i, y);
    end
    x = ~xv;
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (f === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != 66) begin
      errors++;
      $display("FAIL %s_latency: got %0d clocks, expected 66", name, lat);
    end
    checks++;
    if (y !== yexp) begin
      errors++;
      $display("FAIL %s_y: got %0h, expected %0h", name, y, yexp);
    end
    checks++;
    if (i !== 7'd66 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: i=%0d busy=%0b, expected i=66 busy=0", name, i, busy);
    end
    checks++;
    if ((y % 66'd3) !== 66'd0) begin
      errors++;
      $display("FAIL %s_mod3: y mod 3=%0d, expected 0", name, y % 66'd3);
    end
  endtask

  // Drop e from DONE: f and i clear on the next edge, y retained.
  task automatic drop_e(input logic [65:0] yexp, input string name);
    e = 1'b0;
    @(posedge clk);
    #1;
    expect_idle({name, "_drop"}, yexp);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    e     = 1'b0;
    x     = 64'd0;
    #12;
    expect_idle("reset_held", 66'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expect_idle("reset_idle", 66'd0);
  endtask

  task automatic test_basic;
    run_op(64'd117, 66'd351, "x117");
    drop_e(66'd351, "x117");
    run_op(64'd425117, 66'd1275351, "x425117");
    drop_e(66'd1275351, "x425117");
  endtask

  task automatic test_wide;
    run_op(64'd4294967295, 66'd12884901885, "x32ones");
    drop_e(66'd12884901885, "x32ones");
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 66'h2_FFFF_FFFF_FFFF_FFFD, "x64ones");
    drop_e(66'h2_FFFF_FFFF_FFFF_FFFD, "x64ones");
    run_op(64'd0, 66'd0, "x0");
    drop_e(66'd0, "x0");
  endtask

  task automatic test_hold;
    int bad;
    run_op(64'd117, 66'd351, "hold");
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      x = 64'(k) * 64'd7919 + 64'd5;
      @(posedge clk);
      #1;
      if (y !== 66'd351 || f !== 1'b1 || i !== 7'd66 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_stable: %0d of 100 clocks changed, expected 0", bad);
    end
    drop_e(66'd351, "hold");
  endtask

  task automatic test_abort;
    int n;
    x = 64'd827425117;
    e = 1'b1;
    n = 0;
    while (i !== 7'd20 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (i !== 7'd20 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_reach: i=%0d busy=%0b, expected i=20 busy=1", i, busy);
    end
    e = 1'b0;
    @(posedge clk);
    #1;
    expect_idle("abort_idle", 66'd0);
    run_op(64'd827425117, 66'd2482275351, "rerun");
    drop_e(66'd2482275351, "rerun");
  endtask

  task automatic test_async_reset;
    x = 64'd425117;
    e = 1'b1;
    repeat (10) @(posedge clk);
    #3;
    checks++;
    if (busy !== 1'b1 || y === 66'd0) begin
      errors++;
      $display("FAIL areset_pre: busy=%0b y=%0h, expected busy=1 y nonzero", busy, y);
    end
    rst_n = 1'b0;
    #1;
    expect_idle("areset_immediate", 66'd0);
    @(negedge clk);
    e     = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_idle("areset_release", 66'd0);
    run_op(64'd117, 66'd351, "post_reset");
    drop_e(66'd351, "post_reset");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_wide();
    test_hold();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_times3_encoder.md
Name: serial_times3_encoder

Overview:
Bit-serial 3N (AN-code, A=3) encoder. It is the transmit-side counterpart of the serial mod-3 residue checker.
- Takes a W-bit operand x and produces y = 3·x, LSB-first, one bit per clock.
- y is computed as x + (x<<1) using a single carry bit.
- Every y it emits satisfies y mod 3 == 0, so the downstream mod-3 checker can validate the codeword.
- Uses the same start/finish convention as the checker: level enable e, done flag f, step index i.

Parameters:
W, 64, operand width; result width is W+2.
IW, $clog2(W+3), width of step index i (7 for W=64).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  reset, asynchronous, active-low.
x  input  W  operand; sampled only on the load edge.
e  input  1  level enable/start; low returns block to idle.
y  output  W+2  encoded result 3·x; built bit by bit; final when f=1.
f  output  1  finished; high while result is valid.
i  output  IW  bit index being produced (0..W+1); W+2 when done.
busy  output  1  high during RUN.

Behaviour:
- Reset: the block is one clock, with reset asynchronous and active-low on rst_n. While rst_n=0:
  - state=IDLE, y=0, f=0, i=0, busy=0.
  - Internal shift register, prev bit and carry are all 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - Waits for e=1 on a rising clk edge (the load edge).
  - On the load edge: sh<=x, prev<=0, carry<=0, y<=0, i<=0, busy<=1, f<=0; go to RUN.
- RUN, one bit per edge:
  - b=sh[0]; s=b+prev+carry (2-bit; max value 3).
  - y[i]<=s[0]; carry<=s[1]; prev<=b; sh<=sh>>1 (zero fill); i<=i+1.
  - Bits W and W+1 consume zero operand bits, which flushes prev and carry.
- RUN exit:
  - The edge that writes bit W+1 (i==W+1) moves to DONE: f<=1, busy<=0, i<=W+2.
- Latency: f rises exactly W+2 clocks after the load edge (66 for W=64).
- DONE:
  - y, f and i hold while e=1; no restart while e stays high.
  - e=0 → IDLE, f<=0, i<=0, y holds its last value.
- Abort: e=0 during RUN → IDLE on that edge: f=0, busy=0, i=0, y<=0. The partial result is discarded.
- x changes after the load edge are ignored.
- Width: no overflow is possible. 3·(2^W−1) < 2^(W+2), and the final carry is always 0.
- Reset mid-RUN or mid-DONE: immediate asynchronous return to the reset values above.
- y mod 3 == 0 holds for every completed result.

Decomposition:
- Package times3_pkg holds:
  - default W;
  - state enum {IDLE, RUN, DONE}, encoded 2-bit;
  - constant LAST_IDX = W+1.
- One natural sub-module: serial_add_cell. It is the combinational 3-input bit adder (b, prev, carry → sum, carry_out). It is instantiated once.
- The FSM, shift register and index counter stay in the top module.

Test Plan:
- Reset low, then e=0 for 2 clocks → y=0, f=0, i=0, busy=0.
- x=117, e high → f rises 66 clocks after the load edge with y=351, i=66. Then x=425117 → y=1275351.
- x=4294967295 → y=12884901885. Then x=2^64−1 → y=0x2_FFFF_FFFF_FFFF_FFFD with no lost carry. Also x=0 → y=0, f=1.
- Hold e high 100 clocks after done → y and f stable, no reload even though x changes. Drop e → f=0 next edge, y retained.
- Drop e at i=20 during x=827425117 → IDLE, y=0, f=0. Re-raise e → full 66-clock run giving y=2482275351.
- Assert rst_n=0 asynchronously mid-RUN, between edges → outputs clear immediately. Release → IDLE. A subsequent run of x=117 gives 351.
